// File: rtl/pulse_sched.sv
// Pulse event sequencer: queues (amp, sel, gap) events in a small FIFO and
// replays them as clean load pulses to the exponential-decay pulse generator.
module pulse_sched #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 14,
  parameter int unsigned SW     = 4,
  parameter int unsigned GW     = 16,
  parameter int unsigned LOAD_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic signed [AW-1:0] wr_amp,
  input  logic        [SW-1:0] wr_sel,
  input  logic        [GW-1:0] wr_gap,
  input  logic                 start,
  input  logic                 stop,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 pg_load,
  output logic signed [AW-1:0] pg_val,
  output logic        [SW-1:0] pg_sel,
  output logic                 busy,
  output logic        [15:0]   pulse_cnt
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned LCW = (LOAD_W > 1) ? $clog2(LOAD_W) : 1;

  typedef struct packed {
    logic signed [AW-1:0] amp;
    logic        [SW-1:0] sel;
    logic        [GW-1:0] gap;
  } evt_t;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, LOAD} state_t;

  state_t         state, state_nxt;
  evt_t           mem [DEPTH];
  evt_t           head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic           push, pop, run;
  logic [GW-1:0]  gap_cnt;
  logic [LCW-1:0] ld_cnt;
  logic [SW-1:0]  sel_lat;

  assign head = mem[rd_ptr];
  assign push = wr_en && !full;
  assign pop  = (state == FETCH) && !empty;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = CW'(count + CW'(1));
      2'b01:   count_nxt = CW'(count - CW'(1));
      default: count_nxt = count;
    endcase
  end

  // Next-state decode; FETCH always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (run && !empty) state_nxt = FETCH;
      FETCH: state_nxt = (gap_cnt == '0) ? LOAD : WAIT;
      WAIT: begin
        if (!run)                    state_nxt = IDLE;
        else if (gap_cnt == GW'(1))  state_nxt = LOAD;
      end
      LOAD: begin
        if (ld_cnt == LCW'(LOAD_W - 1))
          state_nxt = (run && !empty) ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_amp, wr_sel, wr_gap};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      gap_cnt   <= '0;
      ld_cnt    <= '0;
      sel_lat   <= '0;
      pg_load   <= 1'b0;
      pg_val    <= '0;
      pg_sel    <= '0;
      busy      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state    <= state_nxt;
      run      <= stop ? 1'b0 : (start ? 1'b1 : run);
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      empty    <= (count_nxt == '0);
      overflow <= wr_en && full;
      if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
      if (pop)  rd_ptr <= PW'(rd_ptr + PW'(1));

      busy    <= (state_nxt != IDLE);
      pg_load <= (state_nxt == LOAD);

      // Present the head amplitude during FETCH so it leads the load edge.
      if (state_nxt == FETCH) begin
        pg_val  <= head.amp;
        sel_lat <= head.sel;
        gap_cnt <= head.gap;
      end else if (state == WAIT && gap_cnt != '0) begin
        gap_cnt <= GW'(gap_cnt - GW'(1));
      end

      if (state_nxt == LOAD && state != LOAD) begin
        pg_sel    <= sel_lat;
        pulse_cnt <= 16'(pulse_cnt + 16'(1));
        ld_cnt    <= '0;
      end else if (state == LOAD) begin
        ld_cnt <= LCW'(ld_cnt + LCW'(1));
      end
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: a cycle table for a single event plus
// hand-written sequences for back-to-back, overflow, stop and reset cases.
module tb_pulse_sched;

  localparam int unsigned AW = 14;
  localparam int unsigned SW = 4;
  localparam int unsigned GW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic signed [AW-1:0] wr_amp = '0;
  logic        [SW-1:0] wr_sel = '0;
  logic        [GW-1:0] wr_gap = '0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 full, empty, overflow, pg_load, busy;
  logic signed [AW-1:0] pg_val;
  logic        [SW-1:0] pg_sel;
  logic        [15:0]   pulse_cnt;

  pulse_sched dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_amp(wr_amp), .wr_sel(wr_sel),
    .wr_gap(wr_gap), .start(start), .stop(stop), .full(full), .empty(empty),
    .overflow(overflow), .pg_load(pg_load), .pg_val(pg_val), .pg_sel(pg_sel),
    .busy(busy), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  // Pulse monitor: records amplitude/sel at each rising load edge plus
  // high and low run lengths, sampled on the falling clock edge.
  int   val_q[$], sel_q[$], hi_q[$], lo_q[$];
  int   hi_len = 0, lo_len = 0;
  logic prev_load = 1'b0;
  logic seen_any = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      if (pg_load && !prev_load) begin
        val_q.push_back(int'($signed(pg_val)));
        sel_q.push_back(int'(pg_sel));
        if (seen_any) lo_q.push_back(lo_len);
        seen_any = 1'b1;
        hi_len = 1;
      end else if (pg_load) begin
        hi_len++;
      end else if (prev_load) begin
        hi_q.push_back(hi_len);
        lo_len = 1;
      end else begin
        lo_len++;
      end
      prev_load = pg_load;
    end
  end

  task automatic clear_mon();
    val_q.delete(); sel_q.delete(); hi_q.delete(); lo_q.delete();
    seen_any = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int amp, input int sel, input int gap);
    wr_en = 1'b1; wr_amp = AW'(amp); wr_sel = SW'(sel); wr_gap = GW'(gap);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic strobe(input logic s_start, input logic s_stop);
    start = s_start; stop = s_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    do begin tick(); n++; end while (!(!busy && empty) && n < bound);
    check({name, "_idle_in_time"}, 32'(!busy && empty), 1);
    tick(); tick();
  endtask

  typedef struct {
    logic wr; int amp; int sel; int gap; logic st; logic sp;
    logic e_load; int e_val; int e_sel; logic e_busy; int e_cnt;
    logic e_full; logic e_empty;
  } vec_t;

  function automatic vec_t mk(logic wr, int amp, int sel, int gap, logic st,
                              logic sp, logic el, int ev, int es, logic eb,
                              int ec, logic ef, logic ee);
    vec_t v;
    v.wr = wr; v.amp = amp; v.sel = sel; v.gap = gap; v.st = st; v.sp = sp;
    v.e_load = el; v.e_val = ev; v.e_sel = es; v.e_busy = eb; v.e_cnt = ec;
    v.e_full = ef; v.e_empty = ee;
    return v;
  endfunction

  vec_t tv[11];
  int   n_wait;

  initial begin
    // Single event (8000, sel 2, gap 5): FETCH seen after vector 2,
    // load high after vectors 8 and 9, back to idle after vector 10.
    tv[0]  = mk(1, 8000, 2, 5, 0, 0,  0,    0, 0, 0, 0, 0, 0);
    tv[1]  = mk(0,    0, 0, 0, 1, 0,  0,    0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0,    0, 0, 0, 0, 0,  0, 8000, 0, 1, 0, 0, 0);
    for (int i = 3; i < 8; i++)
      tv[i] = mk(0,   0, 0, 0, 0, 0,  0, 8000, 0, 1, 0, 0, 1);
    tv[8]  = mk(0,    0, 0, 0, 0, 0,  1, 8000, 2, 1, 1, 0, 1);
    tv[9]  = mk(0,    0, 0, 0, 0, 0,  1, 8000, 2, 1, 1, 0, 1);
    tv[10] = mk(0,    0, 0, 0, 0, 0,  0, 8000, 2, 0, 1, 0, 1);

    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_empty", 32'(empty), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(pulse_cnt), 0);

    // Reset in the middle of a 50-cycle wait.
    clear_mon();
    push(1000, 3, 50);
    strobe(1'b1, 1'b0);
    repeat (20) tick();
    check("mid_wait_busy", 32'(busy), 1);
    check("mid_wait_val", $signed(pg_val), 1000);
    #2 rst = 1'b1;
    #1;
    check("arst_load", 32'(pg_load), 0);
    check("arst_val", $signed(pg_val), 0);
    check("arst_sel", 32'(pg_sel), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_full", 32'(full), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_cnt", 32'(pulse_cnt), 0);
    @(negedge clk) rst = 1'b0;
    repeat (60) tick();
    check("arst_no_pulse", val_q.size(), 0);
    check("arst_still_idle", 32'(busy), 0);

    // Table-driven single event.
    clear_mon();
    for (int i = 0; i < 11; i++) begin
      wr_en = tv[i].wr; wr_amp = AW'(tv[i].amp); wr_sel = SW'(tv[i].sel);
      wr_gap = GW'(tv[i].gap); start = tv[i].st; stop = tv[i].sp;
      tick();
      check($sformatf("v%0d_load", i), 32'(pg_load), 32'(tv[i].e_load));
      check($sformatf("v%0d_val", i), $signed(pg_val), tv[i].e_val);
      check($sformatf("v%0d_sel", i), 32'(pg_sel), tv[i].e_sel);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      check($sformatf("v%0d_cnt", i), 32'(pulse_cnt), tv[i].e_cnt);
      check($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].e_full));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].e_empty));
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;

    // Back-to-back gap=0 events while running.
    clear_mon();
    push(100, 0, 0);
    push(200, 1, 0);
    push(300, 2, 0);
    wait_idle("b2b", 40);
    check("b2b_npulse", val_q.size(), 3);
    check("b2b_v0", val_q[0], 100);
    check("b2b_v1", val_q[1], 200);
    check("b2b_v2", val_q[2], 300);
    check("b2b_s2", sel_q[2], 2);
    check("b2b_hi0", hi_q[0], 2);
    check("b2b_hi2", hi_q[2], 2);
    check("b2b_lo0", lo_q[0], 1);
    check("b2b_lo1", lo_q[1], 1);
    check("b2b_cnt", 32'(pulse_cnt), 4);

    // Fill while disarmed; fifth write overflows.
    strobe(1'b0, 1'b1);
    clear_mon();
    for (int i = 1; i <= 5; i++) begin
      push(11 * i, i, 0);
      check($sformatf("fill%0d_full", i), 32'(full), (i >= 4) ? 1 : 0);
      check($sformatf("fill%0d_ovf", i), 32'(overflow), (i == 5) ? 1 : 0);
    end
    tick();
    check("ovf_one_cycle", 32'(overflow), 0);
    check("fill_no_pulse", val_q.size(), 0);
    strobe(1'b1, 1'b0);
    wait_idle("drain", 60);
    check("drain_npulse", val_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_v%0d", i), val_q[i], 11 * (i + 1));
    check("drain_s3", sel_q[3], 4);
    check("drain_cnt", 32'(pulse_cnt), 8);

    // Stop during a long wait aborts the event.
    clear_mon();
    push(700, 5, 100);
    repeat (11) tick();
    check("stopw_busy", 32'(busy), 1);
    strobe(1'b0, 1'b1);
    tick();
    check("stopw_idle", 32'(busy), 0);
    repeat (120) tick();
    check("stopw_no_pulse", val_q.size(), 0);
    check("stopw_cnt", 32'(pulse_cnt), 8);
    check("stopw_empty", 32'(empty), 1);

    // Stop during the first load cycle: pulse completes, queue kept.
    clear_mon();
    push(1, 1, 0);
    push(2, 2, 0);
    push(3, 3, 0);
    strobe(1'b1, 1'b0);
    n_wait = 0;
    while (!pg_load && n_wait < 10) begin tick(); n_wait++; end
    check("stopl_load_seen", 32'(pg_load), 1);
    strobe(1'b0, 1'b1);
    check("stopl_load_held", 32'(pg_load), 1);
    tick();
    check("stopl_load_low", 32'(pg_load), 0);
    check("stopl_idle", 32'(busy), 0);
    repeat (5) tick();
    check("stopl_kept", 32'(empty), 0);
    check("stopl_npulse", val_q.size(), 1);
    check("stopl_hi", hi_q[0], 2);
    check("stopl_cnt", 32'(pulse_cnt), 9);
    strobe(1'b1, 1'b0);
    wait_idle("stopl_rest", 40);
    check("stopl_v1", val_q[1], 2);
    check("stopl_v2", val_q[2], 3);
    check("stopl_cnt2", 32'(pulse_cnt), 11);

    // Armed with an empty FIFO: a late write is scheduled automatically.
    clear_mon();
    repeat (10) tick();
    push(-500, 4, 0);
    wait_idle("cont", 20);
    check("cont_npulse", val_q.size(), 1);
    check("cont_val", val_q[0], -500);
    check("cont_sel", sel_q[0], 4);
    check("cont_pg_val", $signed(pg_val), -500);
    check("cont_cnt", 32'(pulse_cnt), 12);

    // start and stop together leave the sequencer disarmed.
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    clear_mon();
    push(9, 1, 0);
    repeat (10) tick();
    check("ss_busy", 32'(busy), 0);
    check("ss_no_pulse", val_q.size(), 0);
    check("ss_pending", 32'(empty), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
